// File: rtl/exec_wb_stage_if.sv
// ==== exec_wb_stage_if : issue handshake, register-file ports, status ====
// ==== Rev 1.0 ============================================================
`default_nettype none

interface exec_wb_stage_if;
  logic        In_Valid;
  logic        In_Ready;
  logic [2:0]  Op;
  logic [3:0]  Rs1;
  logic [3:0]  Rs2;
  logic [3:0]  Rd;
  logic        Hold;
  logic [3:0]  Re1;
  logic [3:0]  Re2;
  logic [15:0] D1;
  logic [15:0] D2;
  logic [3:0]  W;
  logic [15:0] Da;
  logic        WEn;
  logic        Zero;
  logic        Carry;
  logic [7:0]  Retired;

  modport slave (
    input  In_Valid, Op, Rs1, Rs2, Rd, Hold, D1, D2,
    output In_Ready, Re1, Re2, W, Da, WEn, Zero, Carry, Retired
  );

  modport master (
    output In_Valid, Op, Rs1, Rs2, Rd, Hold, D1, D2,
    input  In_Ready, Re1, Re2, W, Da, WEn, Zero, Carry, Retired
  );
endinterface

`default_nettype wire

// File: rtl/exec_wb_stage.sv
// ==== exec_wb_stage : two-stage 16-bit ALU with EX/WB forwarding ====
// ==== Rev 1.0 =======================================================
`default_nettype none

module exec_wb_stage (
  input  logic           Clk,
  input  logic           Rst,
  exec_wb_stage_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic [3:0]  ex_rd;
  logic [15:0] ex_result;
  logic        ex_carry;
  logic        ex_zero;

  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_result;
  logic        wb_zero;
  logic        wb_carry;

  logic        zero_q;
  logic        carry_q;
  logic [7:0]  retired_q;

  logic        accept;
  logic        wen;
  logic [15:0] opnd_a;
  logic [15:0] opnd_b;

  assign accept       = bus.In_Valid & ~bus.Hold;
  assign wen          = wb_valid & ~bus.Hold;
  assign bus.In_Ready = ~bus.Hold;
  assign bus.Re1      = bus.Rs1;
  assign bus.Re2      = bus.Rs2;
  assign bus.W        = wb_rd;
  assign bus.Da       = wb_result;
  assign bus.WEn      = wen;
  assign bus.Zero     = zero_q;
  assign bus.Carry    = carry_q;
  assign bus.Retired  = retired_q;

  // The youngest producer wins: EX is newer than WB, which is newer than the file.
  always_comb begin
    opnd_a = bus.D1;
    if (ex_valid && (ex_rd == bus.Rs1))
      opnd_a = ex_result;
    else if (wb_valid && (wb_rd == bus.Rs1))
      opnd_a = wb_result;

    opnd_b = bus.D2;
    if (ex_valid && (ex_rd == bus.Rs2))
      opnd_b = ex_result;
    else if (wb_valid && (wb_rd == bus.Rs2))
      opnd_b = wb_result;
  end

  always_comb begin
    ex_result = 16'h0000;
    ex_carry  = 1'b0;
    case (ex_op)
      OP_ADD:  {ex_carry, ex_result} = {1'b0, ex_a} + {1'b0, ex_b};
      OP_SUB: begin
        ex_result = ex_a - ex_b;
        ex_carry  = (ex_a < ex_b);
      end
      OP_AND:  ex_result = ex_a & ex_b;
      OP_OR:   ex_result = ex_a | ex_b;
      OP_XOR:  ex_result = ex_a ^ ex_b;
      OP_SHL: begin
        ex_result = {ex_a[14:0], 1'b0};
        ex_carry  = ex_a[15];
      end
      OP_SHR: begin
        ex_result = {1'b0, ex_a[15:1]};
        ex_carry  = ex_a[0];
      end
      OP_MOV:  ex_result = ex_a;
      default: ex_result = 16'h0000;
    endcase
    ex_zero = (ex_result == 16'h0000);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_valid <= 1'b0;
      ex_op    <= OP_ADD;
      ex_a     <= 16'h0000;
      ex_b     <= 16'h0000;
      ex_rd    <= 4'd0;
    end else if (!bus.Hold) begin
      ex_valid <= accept;
      if (accept) begin
        ex_op <= bus.Op;
        ex_a  <= opnd_a;
        ex_b  <= opnd_b;
        ex_rd <= bus.Rd;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wb_valid  <= 1'b0;
      wb_rd     <= 4'd0;
      wb_result <= 16'h0000;
      wb_zero   <= 1'b0;
      wb_carry  <= 1'b0;
    end else if (!bus.Hold) begin
      wb_valid  <= ex_valid;
      wb_rd     <= ex_rd;
      wb_result <= ex_result;
      wb_zero   <= ex_zero;
      wb_carry  <= ex_carry;
    end
  end

  // Status reflects only instructions that actually reached the register file.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      retired_q <= 8'd0;
    end else if (wen) begin
      zero_q    <= wb_zero;
      carry_q   <= wb_carry;
      retired_q <= retired_q + 8'd1;
    end
  end
endmodule

`default_nettype wire

// File: doc/exec_wb_stage.md
EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

Interface
REQ-001 SHALL have ports: Clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: Rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have: In_Valid  in  1  instruction offered this cycle.
REQ-004 SHALL have: In_Ready  out  1  instruction accepted at this edge when In_Valid=1.
REQ-005 SHALL have: Op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1 (logical), 111 MOV (pass A).
REQ-006 SHALL have: Rs1, Rs2, Rd  in  4 each  source and destination register indices.
REQ-007 SHALL have: Hold  in  1  pipeline freeze request.
REQ-008 SHALL have: Re1, Re2  out  4 each  register-file read addresses, combinationally equal to Rs1, Rs2.
REQ-009 SHALL have: D1, D2  in  16 each  register-file read data for Re1, Re2 (combinational read).
REQ-010 SHALL have: W  out  4, Da  out  16, WEn  out  1  register-file write port, registered.
REQ-011 SHALL have: Zero, Carry  out  1 each  flags of the last written-back result, registered.
REQ-012 SHALL have: Retired  out  8  count of write-backs, wraps 255->0.

Function
REQ-013 SHALL be two stages: EX register (valid, Op, A, B, Rd) and WB register (valid, Rd, result, flags).
REQ-014 In_Ready SHALL equal NOT Hold; accept occurs at an edge where In_Valid=1 and In_Ready=1.
REQ-015 On accept, EX SHALL load Op, Rd, and A/B operands; with no accept and Hold=0, EX valid SHALL clear.
REQ-016 Operand select, per operand, priority: EX valid and EX.Rd==Rs -> EX result; else WB valid and WB.Rd==Rs -> WB result; else D1/D2.
REQ-017 With Hold=0, WB SHALL load EX contents and the computed result at each edge; WB valid = EX valid.
REQ-018 With Hold=1, EX and WB SHALL keep their contents, and WEn SHALL be 0 combinationally; the WB instruction is written on the first Hold=0 cycle.
REQ-019 WEn SHALL equal WB valid AND NOT Hold; W = WB.Rd, Da = WB result.
REQ-020 Latency: instruction accepted at edge n SHALL present WEn=1 during cycle n+1..n+2; register file updates at edge n+2.
REQ-021 Arithmetic SHALL be 16-bit, wrapping; ADD Carry = bit 16 carry-out; SUB Carry = borrow (A<B unsigned); SHL1 Carry = A[15]; SHR1 Carry = A[0]; others Carry=0.
REQ-022 Zero SHALL be 1 when result==0x0000.
REQ-023 Zero, Carry, Retired SHALL update only at edges where WEn=1.
REQ-024 Rd=0 SHALL be written like any other register (no hardwired zero).
REQ-025 Back-to-back accepts SHALL sustain one instruction per cycle with no bubbles.

Reset
REQ-026 Rst=0 SHALL immediately clear EX valid, WB valid, WEn, Zero, Carry, Retired; W=0, Da=0x0000.
REQ-027 Instructions in flight at reset SHALL be discarded, not written.
REQ-028 First accept SHALL be possible at the first rising edge after Rst returns to 1.

Verification (register file reset-preloaded with Rk = k)
REQ-029 ADD Rd=3, Rs1=1, Rs2=2 accepted at edge n -> cycle n+1: WEn=1, W=3, Da=0x0003, Zero=0, Carry=0 after edge n+2, Retired=1.
REQ-030 ADD R3=R1+R2 then next cycle ADD R4=R3+R3 -> second write Da=0x0006 (EX forwarding), then ADD R5=R3+R0 one cycle later -> Da=0x0003 (WB forwarding).
REQ-031 SUB Rd=5, Rs1=1, Rs2=2 -> Da=0xFFFF, Carry=1, Zero=0; XOR Rd=6, Rs1=7, Rs2=7 -> Da=0x0000, Zero=1.
REQ-032 Accept ADD, then Hold=1 for 3 cycles -> In_Ready=0, WEn=0, W/Da stable; Hold=0 -> single write with correct Da, Retired increments by exactly 1.
REQ-033 Rst=0 asserted mid-cycle with EX and WB valid -> WEn=0 immediately, no write ever occurs for those instructions, Retired=0.
REQ-034 256 consecutive MOV writes -> Retired wraps to 0x00.
